servant_sleep_ctrl: RTL and testbench

//  Sequences clock gating of the SERV core/Wishbone domain on the Nexys A7 servant top. Takes

---
 rtl/servant_sleep_pkg.sv | 26 ++
 rtl/servant_sync2.sv | 25 ++
 rtl/servant_sleep_ctrl.sv | 127 ++++++++++++
 tb/tb_servant_sleep_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/servant_sleep_pkg.sv
// Shared types and constants for the servant clock-gating sleep controller.
package servant_sleep_pkg;

    // Controller phases: running, draining the bus, clock gated, settling after wake.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } sleep_state_e;

    // Bit positions inside the wake-cause vector.
    localparam int CAUSE_SW    = 0;
    localparam int CAUSE_TIMER = 1;
    localparam int CAUSE_EXT   = 2;

    // Width of the drain/settle counters: enough to hold the larger cycle count, at least 1 bit.
    function automatic int cntWidth(input int drainCycles, input int wakeCycles);
        int maxCycles;
        int w;
        maxCycles = (drainCycles > wakeCycles) ? drainCycles : wakeCycles;
        w = $clog2(maxCycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/servant_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the main clock domain.
module servant_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to let metastability resolve.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/servant_sleep_ctrl.sv
// Sleep controller for the servant SERV core: drains the Wishbone bus, gates the core
// clock enable, and re-enables it on software, timer or external wake events.
module servant_sleep_ctrl
    import servant_sleep_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int WAKE_CYCLES  = 2,
    parameter int SYNC_EXT_IRQ = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sleep_req,
    input  logic        i_wakeup_req,
    input  logic        i_ext_irq,
    input  logic        i_timer_irq,
    input  logic        i_wb_cyc,
    output logic        o_clk_en,
    output logic        o_sleeping,
    output logic [2:0]  o_wake_cause,
    output logic [15:0] o_sleep_cnt
);

    localparam int CW = cntWidth(DRAIN_CYCLES, WAKE_CYCLES);
    localparam int WAKE_LAST_I = (WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES);
    localparam logic [CW-1:0] WAKE_LAST  = CW'(WAKE_LAST_I);

    sleep_state_e  state_q;
    logic          clkEn_q;
    logic          sleeping_q;
    logic [2:0]    wakeCause_q;
    logic [15:0]   sleepCnt_q;
    logic [15:0]   sleepCnt_d;
    logic [CW-1:0] drainCnt_q;
    logic [CW-1:0] settleCnt_q;

    logic          extIrqS;
    logic          wakeEvt;
    logic [2:0]    wakeCauseNow;

    // The external interrupt is only synchronised when it may arrive from another domain.
    generate
        if (SYNC_EXT_IRQ != 0) begin : gSync
            servant_sync2 uExtSync (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_d   (i_ext_irq),
                .o_q   (extIrqS)
            );
        end else begin : gNoSync
            assign extIrqS = i_ext_irq;
        end
    endgenerate

    // Combine the wake sources and build the cause snapshot and saturating entry count.
    always_comb begin
        wakeEvt = i_wakeup_req | extIrqS | i_timer_irq;
        wakeCauseNow = 3'b000;
        wakeCauseNow[CAUSE_SW]    = i_wakeup_req;
        wakeCauseNow[CAUSE_TIMER] = i_timer_irq;
        wakeCauseNow[CAUSE_EXT]   = extIrqS;
        sleepCnt_d = (sleepCnt_q == 16'hFFFF) ? sleepCnt_q : sleepCnt_q + 16'd1;
    end

    // Sleep sequencer with registered clock enable and status outputs; a wake event always beats a sleep request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= RUN;
            clkEn_q     <= 1'b1;
            sleeping_q  <= 1'b0;
            wakeCause_q <= 3'b000;
            sleepCnt_q  <= 16'd0;
            drainCnt_q  <= '0;
            settleCnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (i_sleep_req && !wakeEvt) begin
                        state_q    <= DRAIN;
                        drainCnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (wakeEvt) begin
                        state_q <= RUN;
                    end else if (i_wb_cyc) begin
                        drainCnt_q <= '0;
                    end else if (drainCnt_q == DRAIN_LAST) begin
                        state_q    <= GATED;
                        clkEn_q    <= 1'b0;
                        sleeping_q <= 1'b1;
                        sleepCnt_q <= sleepCnt_d;
                    end else begin
                        drainCnt_q <= drainCnt_q + 1'b1;
                    end
                end
                GATED: begin
                    if (wakeEvt) begin
                        state_q     <= WAKE;
                        clkEn_q     <= 1'b1;
                        wakeCause_q <= wakeCauseNow;
                        settleCnt_q <= '0;
                    end
                end
                WAKE: begin
                    if (settleCnt_q == WAKE_LAST) begin
                        state_q    <= RUN;
                        sleeping_q <= 1'b0;
                    end else begin
                        settleCnt_q <= settleCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    clkEn_q    <= 1'b1;
                    sleeping_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_clk_en     = clkEn_q;
    assign o_sleeping   = sleeping_q;
    assign o_wake_cause = wakeCause_q;
    assign o_sleep_cnt  = sleepCnt_q;

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// Directed testbench for servant_sleep_ctrl with default parameters (drain 4, settle 2, synced ext irq).
module tb_servant_sleep_ctrl;

    logic        clk;
    logic        rst;
    logic        sleepReq;
    logic        wakeupReq;
    logic        extIrq;
    logic        timerIrq;
    logic        wbCyc;
    logic        clkEn;
    logic        sleeping;
    logic [2:0]  wakeCause;
    logic [15:0] sleepCnt;

    int checks;
    int failures;

    servant_sleep_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sleep_req  (sleepReq),
        .i_wakeup_req (wakeupReq),
        .i_ext_irq    (extIrq),
        .i_timer_irq  (timerIrq),
        .i_wb_cyc     (wbCyc),
        .o_clk_en     (clkEn),
        .o_sleeping   (sleeping),
        .o_wake_cause (wakeCause),
        .o_sleep_cnt  (sleepCnt)
    );

    // Free-running main clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all request/interrupt inputs at once.
    task automatic applyStimulus(input logic sReq, input logic wReq, input logic eIrq,
                                 input logic tIrq, input logic cyc);
        sleepReq  = sReq;
        wakeupReq = wReq;
        extIrq    = eIrq;
        timerIrq  = tIrq;
        wbCyc     = cyc;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Linear directed sequence.
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset_clk_en", {15'd0, clkEn}, 16'd1);
        rst = 1'b0;

        // Idle for 100 cycles: the controller must stay running.
        repeat (100) @(negedge clk);
        checkOutput("idle_clk_en", {15'd0, clkEn}, 16'd1);
        checkOutput("idle_sleeping", {15'd0, sleeping}, 16'd0);
        checkOutput("idle_sleep_cnt", sleepCnt, 16'd0);
        checkOutput("idle_wake_cause", {13'd0, wakeCause}, 16'd0);

        // Sleep with an idle bus: gating on the fifth edge after the request edge.
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("drain_enter_clk_en", {15'd0, clkEn}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("drain_idle_clk_en", {15'd0, clkEn}, 16'd1);
        end
        @(negedge clk);
        checkOutput("gated_clk_en", {15'd0, clkEn}, 16'd0);
        checkOutput("gated_sleeping", {15'd0, sleeping}, 16'd1);
        checkOutput("gated_sleep_cnt", sleepCnt, 16'd1);

        // Software wake: clock returns on the next edge, sleeping drops two edges later.
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("sw_wake_clk_en", {15'd0, clkEn}, 16'd1);
        checkOutput("sw_wake_cause", {13'd0, wakeCause}, 16'h0001);
        checkOutput("sw_wake_sleeping0", {15'd0, sleeping}, 16'd1);
        @(negedge clk);
        checkOutput("sw_wake_sleeping1", {15'd0, sleeping}, 16'd1);
        @(negedge clk);
        checkOutput("sw_wake_sleeping2", {15'd0, sleeping}, 16'd0);

        // Bus busy for three cycles inside DRAIN restarts the idle count.
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        checkOutput("busy_drain_hold", {15'd0, clkEn}, 16'd1);
        @(negedge clk);
        checkOutput("busy_drain_gated", {15'd0, clkEn}, 16'd0);
        checkOutput("busy_drain_cnt", sleepCnt, 16'd2);

        // External interrupt through the synchroniser: clock returns three edges later.
        applyStimulus(0, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("ext_edge1_clk_en", {15'd0, clkEn}, 16'd0);
        @(negedge clk);
        checkOutput("ext_edge2_clk_en", {15'd0, clkEn}, 16'd0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ext_edge3_clk_en", {15'd0, clkEn}, 16'd1);
        checkOutput("ext_wake_cause", {13'd0, wakeCause}, 16'h0004);
        repeat (2) @(negedge clk);
        checkOutput("ext_settled_sleeping", {15'd0, sleeping}, 16'd0);

        // Timer interrupt during DRAIN aborts without counting a sleep.
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        checkOutput("abort_clk_en", {15'd0, clkEn}, 16'd1);
        checkOutput("abort_sleeping", {15'd0, sleeping}, 16'd0);
        checkOutput("abort_sleep_cnt", sleepCnt, 16'd2);

        // Sleep request together with a timer interrupt is refused.
        applyStimulus(1, 0, 0, 1, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("refuse_clk_en", {15'd0, clkEn}, 16'd1);
            @(negedge clk);
        end
        checkOutput("refuse_sleep_cnt", sleepCnt, 16'd2);

        // Preload the entry counter just below saturation, then sleep twice.
        dut.sleepCnt_q <= 16'hFFFE;
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        checkOutput("sat1_clk_en", {15'd0, clkEn}, 16'd0);
        checkOutput("sat1_sleep_cnt", sleepCnt, 16'hFFFF);
        applyStimulus(0, 0, 0, 1, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("timer_wake_clk_en", {15'd0, clkEn}, 16'd1);
        checkOutput("timer_wake_cause", {13'd0, wakeCause}, 16'h0002);
        repeat (3) @(negedge clk);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        checkOutput("sat2_clk_en", {15'd0, clkEn}, 16'd0);
        checkOutput("sat2_sleep_cnt", sleepCnt, 16'hFFFF);

        // Asynchronous reset while gated restores the clock immediately and clears status.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_clk_en", {15'd0, clkEn}, 16'd1);
        checkOutput("async_rst_sleeping", {15'd0, sleeping}, 16'd0);
        checkOutput("async_rst_sleep_cnt", sleepCnt, 16'd0);
        checkOutput("async_rst_wake_cause", {13'd0, wakeCause}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_clk_en", {15'd0, clkEn}, 16'd1);
        checkOutput("post_rst_sleeping", {15'd0, sleeping}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
